// File: rtl/gpx2_pkg.sv
// Shared GPX2 definitions: TDC SPI opcodes, the frame-sequencer state encoding
// and the filler byte clocked out while reading payload.
package gpx2_pkg;

  localparam logic [7:0] GPX2_OPC_POWER  = 8'h30;
  localparam logic [7:0] GPX2_OPC_INIT   = 8'h18;
  localparam logic [7:0] GPX2_OPC_WRCFG  = 8'h80;
  localparam logic [7:0] GPX2_OPC_RDCFG  = 8'h40;
  localparam logic [7:0] GPX2_OPC_RDRES  = 8'h60;

  localparam logic [7:0] GPX2_DUMMY_BYTE = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CS_SETUP  = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_BYTE = 3'd3,
    ST_CS_HOLD   = 3'd4,
    ST_CS_GAP    = 3'd5
  } frame_state_e;

endpackage

// File: rtl/gpx2_spi_frame_ctrl.sv
// Frame sequencer for the GPX2 SPI link: owns chip-select timing and feeds the
// byte-level master one byte per req/rdvalid exchange.
module gpx2_spi_frame_ctrl
  import gpx2_pkg::*;
#(
  parameter int          LEN_W         = 5,
  parameter logic [7:0]  CS_SETUP_CLKS = 8'd4,
  parameter logic [7:0]  CS_HOLD_CLKS  = 8'd4,
  parameter logic [7:0]  CS_GAP_CLKS   = 8'd8,
  parameter logic [15:0] TIMEOUT_CLKS  = 16'd1023
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [7:0]       i_cmd_opcode,
  input  logic [LEN_W-1:0] i_cmd_len,
  input  logic             i_cmd_rd,
  input  logic             i_wr_valid,
  output logic             o_wr_ready,
  input  logic [7:0]       i_wr_data,
  output logic             o_rd_valid,
  output logic [7:0]       o_rd_data,
  output logic             o_rd_last,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic             o_spi_csn,
  output logic             o_spicom_req,
  output logic [7:0]       o_spi_wdata,
  input  logic             i_spicom_ready,
  input  logic             i_spi_rdvalid,
  input  logic [7:0]       i_spi_rdbyte
);

  // Handshakes: a command, write byte or byte-master request transfers on the
  // cycle where its valid (req) and ready are both high; nothing is retracted.

  localparam logic [15:0] SETUP_LAST = {8'd0, CS_SETUP_CLKS} - 16'd1;
  localparam logic [15:0] HOLD_LAST  = {8'd0, CS_HOLD_CLKS} - 16'd1;
  localparam logic [15:0] GAP_LAST   = {8'd0, CS_GAP_CLKS} - 16'd1;
  localparam logic [15:0] TO_LAST    = TIMEOUT_CLKS - 16'd1;

  frame_state_e     state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [LEN_W:0]   idx_q, idx_d;
  logic [7:0]       opc_q, opc_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             rd_q, rd_d;
  logic             abort_q, abort_d;
  logic             rd_valid_q, rd_valid_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             rd_last_q, rd_last_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             byte_ok;
  logic             last_byte;

  assign last_byte = (idx_q >= {1'b0, len_q});

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 16'd1;
    idx_d        = idx_q;
    opc_d        = opc_q;
    len_d        = len_q;
    rd_d         = rd_q;
    abort_d      = abort_q;
    rd_valid_d   = 1'b0;
    rd_data_d    = rd_data_q;
    rd_last_d    = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;
    byte_ok      = 1'b0;
    o_spicom_req = 1'b0;
    o_wr_ready   = 1'b0;
    o_spi_wdata  = GPX2_DUMMY_BYTE;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = 16'd0;
        if (i_cmd_valid) begin
          opc_d   = i_cmd_opcode;
          len_d   = i_cmd_len;
          rd_d    = i_cmd_rd;
          idx_d   = '0;
          abort_d = 1'b0;
          state_d = ST_CS_SETUP;
        end
      end
      ST_CS_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = 16'd0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d = 16'd0;
        if (idx_q == '0) begin
          o_spi_wdata = opc_q;
          byte_ok     = 1'b1;
        end else if (rd_q) begin
          byte_ok     = 1'b1;
        end else begin
          // Write payload stalls here without a timeout until data arrives.
          o_spi_wdata = i_wr_data;
          o_wr_ready  = i_spicom_ready;
          byte_ok     = i_wr_valid;
        end
        if (byte_ok && i_spicom_ready) begin
          o_spicom_req = 1'b1;
          state_d      = ST_WAIT_BYTE;
        end
      end
      ST_WAIT_BYTE: begin
        if (i_spi_rdvalid) begin
          cnt_d = 16'd0;
          if (rd_q && (idx_q != '0)) begin
            rd_valid_d = 1'b1;
            rd_data_d  = i_spi_rdbyte;
            rd_last_d  = (idx_q == {1'b0, len_q});
          end
          idx_d   = idx_q + 1'b1;
          state_d = last_byte ? ST_CS_HOLD : ST_ISSUE;
        end else if (cnt_q == TO_LAST) begin
          cnt_d   = 16'd0;
          err_d   = 1'b1;
          abort_d = 1'b1;
          state_d = ST_CS_HOLD;
        end
      end
      ST_CS_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = 16'd0;
          done_d  = !abort_q;
          state_d = ST_CS_GAP;
        end
      end
      ST_CS_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = 16'd0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 16'd0;
      idx_q      <= '0;
      opc_q      <= 8'd0;
      len_q      <= '0;
      rd_q       <= 1'b0;
      abort_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'd0;
      rd_last_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      opc_q      <= opc_d;
      len_q      <= len_d;
      rd_q       <= rd_d;
      abort_q    <= abort_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_last_q  <= rd_last_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // CS is decoded from state so reset releases it in the same instant.
  assign o_spi_csn   = (state_q == ST_IDLE) || (state_q == ST_CS_GAP);
  assign o_cmd_ready = (state_q == ST_IDLE);
  assign o_busy      = (state_q != ST_IDLE);
  assign o_rd_valid  = rd_valid_q;
  assign o_rd_data   = rd_data_q;
  assign o_rd_last   = rd_last_q;
  assign o_done      = done_q;
  assign o_err       = err_q;

endmodule
